id_ex_pipeline_register: RTL and testbench
==========================================

// Module: id_ex_pipeline_register
// PURPOSE
//   ID/EX pipeline boundary directly downstream of the control unit.
//   Each cycle it captures the decoded control bundle, the register-file operands, the PC and the instruction.
//   It presents them to the EX stage on the next cycle.
//   It includes load-use hazard detection (stall + bubble injection) and branch flush (bubble injection).
//   It also keeps a saturating stall-cycle counter for performance debug.
// PARAMETERS
//   DATA_W   32  operand / PC / instruction width
//   REG_AW   5   register-index width (32 GPRs; GR0 hard-wired zero)
//   CNT_W    16  stall counter width
// PORTS
//   clk            in   1       system clock, rising edge
//   rst_n          in   1       asynchronous active-low reset
//   id_srd         in   2       SRD from control unit
//   id_psw_le_re   in   2       PSW load/read enable
//   id_b           in   1       branch
//   id_soh_op      in   3       operand-handler opcode
//   id_alu_op      in   4       ALU opcode
//   id_ram_ctrl    in   4       RAM control
//   id_l           in   1       select RAM dataout (load)
//   id_rf_le       in   1       register-file load enable
//   id_ub          in   1       unconditional branch
//   id_id_sr       in   2       source usage: [1]=GR[a] read, [0]=GR[b] read
//   id_ra          in   REG_AW  source index a
//   id_rb          in   REG_AW  source index b
//   id_rd          in   REG_AW  destination index (already selected per SRD)
//   id_pa          in   DATA_W  GR[a] value
//   id_pb          in   DATA_W  GR[b] value
//   id_pc          in   DATA_W  PC of ID instruction
//   id_instr       in   DATA_W  ID instruction word
//   ex_flush       in   1       branch resolved taken in EX; squash ID instruction
//   ex_*           out  --      registered copies of every id_* above except id_id_sr/id_ra/id_rb (same widths)
//   stall          out  1       combinational; 1 = hold PC and IF/ID register this cycle
//   stall_count    out  CNT_W   cycles in which stall was 1, saturating
// BEHAVIOUR
//   Reset (rst_n=0, async):
//     - All ex_* = 0; this is a NOP bubble.
//     - stall_count = 0.
//     - stall evaluates to 0 because ex_l=0.
//   Hazard (combinational, from current ID inputs + registered EX state):
//     - load_use = ex_l & ex_rf_le & (ex_rd!=0) & ((id_id_sr[1] & id_ra==ex_rd) | (id_id_sr[0] & id_rb==ex_rd)).
//     - stall = load_use & ~ex_flush.
//   Priority on each rising edge, highest first:
//     1. ex_flush=1 -> EX regs load bubble (all control, data, pc, instr = 0). stall forced 0 (ID instr is dead).
//     2. stall=1    -> EX regs load bubble. ID instruction is held upstream and re-presented next cycle.
//     3. otherwise  -> EX regs load id_* unchanged.
//   Latency: exactly 1 cycle ID->EX. A load-use pair costs exactly 1 bubble.
//     - Next cycle ex_l=0, so stall deasserts automatically; no multi-cycle stall from one load.
//   Bubble encoding equals the all-zero NOP decode, so EX needs no valid bit.
//   GR0 as destination never causes a stall.
//   id_id_sr=00 (e.g. LDIL, BL) never stalls.
//   stall_count: +1 on each edge where stall=1; holds at {CNT_W{1}} (no wrap).
//     - Unaffected by flush cycles.
//   Reset asserted mid-stall: bubble state and counter clear immediately; stall drops with ex_l.
// STRUCTURE
//   Shared package (cpu_pkg):
//     - typedef ctrl_bundle_t: packed struct srd, psw_le_re, b, soh_op, alu_op, ram_ctrl, l, rf_le, ub = 19 bits.
//     - localparam CTRL_NOP = '0.
//     - localparam REG_ZERO = 0.
//   One sub-module: load_use_hazard_unit.
//     - Purely combinational.
//     - Inputs: id_id_sr, id_ra, id_rb, ex_l, ex_rf_le, ex_rd, ex_flush.
//     - Output: stall.
//   Top keeps the registers and the counter.
// TESTING
//   1. Reset: rst_n=0 mid-run -> all ex_*=0, stall=0, stall_count=0 without a clock edge.
//   2. Pass-through: ADD (ALU_OP=0000, RF_LE=1, rd=3, pa=5, pb=7, pc=0x40)
//      -> next cycle ex_alu_op=0000, ex_rd=3, ex_pa=5, ex_pb=7, ex_pc=0x40.
//   3. Load-use: EX=LDW rd=4 (L=1, RF_LE=1); ID=ADD ra=4, id_sr=11
//      -> stall=1 for 1 cycle, ex_*=0 next edge, stall_count=1; ADD lands in EX one cycle later.
//   4. No false hazard:
//      - EX=LDW rd=0 with ID ra=0 -> stall=0.
//      - EX=LDW rd=4 with ID=LDIL (id_sr=00) -> stall=0.
//   5. Flush vs stall: load-use condition plus ex_flush=1 the same cycle
//      -> stall=0, ex_* bubble next edge, stall_count unchanged.
//   6. Saturation: CNT_W=4, 20 consecutive load-use pairs -> stall_count stops at 15.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared decode types and constants for the ID/EX boundary
package cpu_pkg;

   typedef struct packed {
      logic [1:0] srd;
      logic [1:0] psw_le_re;
      logic       b;
      logic [2:0] soh_op;
      logic [3:0] alu_op;
      logic [3:0] ram_ctrl;
      logic       l;
      logic       rf_le;
      logic       ub;
   } ctrl_bundle_t;

   localparam ctrl_bundle_t CTRL_NOP = '0;
   localparam int           REG_ZERO = 0;

endpackage

// File: rtl/load_use_hazard_unit.sv
// rtl/load_use_hazard_unit.sv - combinational load-use stall detection
module load_use_hazard_unit
   import cpu_pkg::*;
#(
   parameter int REG_AW = 5
) (
   input  logic [1:0]        id_id_sr,
   input  logic [REG_AW-1:0] id_ra,
   input  logic [REG_AW-1:0] id_rb,
   input  logic              ex_l,
   input  logic              ex_rf_le,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_flush,
   output logic              stall
);

   logic rd_live;
   logic src_match;
   logic load_use;

   // GR0 is hard-wired zero, so a load targeting it never produces a dependency
   assign rd_live   = ex_rd != REG_AW'(REG_ZERO);
   assign src_match = (id_id_sr[1] && (id_ra == ex_rd)) ||
                      (id_id_sr[0] && (id_rb == ex_rd));
   assign load_use  = ex_l && ex_rf_le && rd_live && src_match;
   assign stall     = load_use && !ex_flush;

endmodule

// File: rtl/id_ex_pipeline_register.sv
// rtl/id_ex_pipeline_register.sv - ID/EX register with bubble injection and stall counter
module id_ex_pipeline_register
   import cpu_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [1:0]        id_srd,
   input  logic [1:0]        id_psw_le_re,
   input  logic              id_b,
   input  logic [2:0]        id_soh_op,
   input  logic [3:0]        id_alu_op,
   input  logic [3:0]        id_ram_ctrl,
   input  logic              id_l,
   input  logic              id_rf_le,
   input  logic              id_ub,
   input  logic [1:0]        id_id_sr,
   input  logic [REG_AW-1:0] id_ra,
   input  logic [REG_AW-1:0] id_rb,
   input  logic [REG_AW-1:0] id_rd,
   input  logic [DATA_W-1:0] id_pa,
   input  logic [DATA_W-1:0] id_pb,
   input  logic [DATA_W-1:0] id_pc,
   input  logic [DATA_W-1:0] id_instr,
   input  logic              ex_flush,
   output logic [1:0]        ex_srd,
   output logic [1:0]        ex_psw_le_re,
   output logic              ex_b,
   output logic [2:0]        ex_soh_op,
   output logic [3:0]        ex_alu_op,
   output logic [3:0]        ex_ram_ctrl,
   output logic              ex_l,
   output logic              ex_rf_le,
   output logic              ex_ub,
   output logic [REG_AW-1:0] ex_rd,
   output logic [DATA_W-1:0] ex_pa,
   output logic [DATA_W-1:0] ex_pb,
   output logic [DATA_W-1:0] ex_pc,
   output logic [DATA_W-1:0] ex_instr,
   output logic              stall,
   output logic [CNT_W-1:0]  stall_count
);

   ctrl_bundle_t id_ctrl;
   ctrl_bundle_t ex_ctrl;
   logic         bubble;

   assign id_ctrl = '{srd:       id_srd,
                      psw_le_re: id_psw_le_re,
                      b:         id_b,
                      soh_op:    id_soh_op,
                      alu_op:    id_alu_op,
                      ram_ctrl:  id_ram_ctrl,
                      l:         id_l,
                      rf_le:     id_rf_le,
                      ub:        id_ub};

   load_use_hazard_unit #(.REG_AW(REG_AW)) u_hazard (
      .id_id_sr (id_id_sr),
      .id_ra    (id_ra),
      .id_rb    (id_rb),
      .ex_l     (ex_ctrl.l),
      .ex_rf_le (ex_ctrl.rf_le),
      .ex_rd    (ex_rd),
      .ex_flush (ex_flush),
      .stall    (stall)
   );

   // A bubble is the all-zero NOP decode, so EX needs no separate valid bit
   assign bubble = ex_flush || stall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_ctrl  <= CTRL_NOP;
         ex_rd    <= '0;
         ex_pa    <= '0;
         ex_pb    <= '0;
         ex_pc    <= '0;
         ex_instr <= '0;
      end else if (bubble) begin
         ex_ctrl  <= CTRL_NOP;
         ex_rd    <= '0;
         ex_pa    <= '0;
         ex_pb    <= '0;
         ex_pc    <= '0;
         ex_instr <= '0;
      end else begin
         ex_ctrl  <= id_ctrl;
         ex_rd    <= id_rd;
         ex_pa    <= id_pa;
         ex_pb    <= id_pb;
         ex_pc    <= id_pc;
         ex_instr <= id_instr;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_count <= '0;
      end else if (stall && (stall_count != {CNT_W{1'b1}})) begin
         stall_count <= stall_count + CNT_W'(1);
      end
   end

   assign ex_srd       = ex_ctrl.srd;
   assign ex_psw_le_re = ex_ctrl.psw_le_re;
   assign ex_b         = ex_ctrl.b;
   assign ex_soh_op    = ex_ctrl.soh_op;
   assign ex_alu_op    = ex_ctrl.alu_op;
   assign ex_ram_ctrl  = ex_ctrl.ram_ctrl;
   assign ex_l         = ex_ctrl.l;
   assign ex_rf_le     = ex_ctrl.rf_le;
   assign ex_ub        = ex_ctrl.ub;

endmodule

// File: tb/tb_id_ex_pipeline_register.sv
// tb/tb_id_ex_pipeline_register.sv - directed self-checking bench for id_ex_pipeline_register
module tb_id_ex_pipeline_register;

   localparam int DATA_W = 32;
   localparam int REG_AW = 5;
   localparam int CNT_W  = 4;

   logic              clk;
   logic              rst_n;
   logic [1:0]        id_srd;
   logic [1:0]        id_psw_le_re;
   logic              id_b;
   logic [2:0]        id_soh_op;
   logic [3:0]        id_alu_op;
   logic [3:0]        id_ram_ctrl;
   logic              id_l;
   logic              id_rf_le;
   logic              id_ub;
   logic [1:0]        id_id_sr;
   logic [REG_AW-1:0] id_ra;
   logic [REG_AW-1:0] id_rb;
   logic [REG_AW-1:0] id_rd;
   logic [DATA_W-1:0] id_pa;
   logic [DATA_W-1:0] id_pb;
   logic [DATA_W-1:0] id_pc;
   logic [DATA_W-1:0] id_instr;
   logic              ex_flush;
   logic [1:0]        ex_srd;
   logic [1:0]        ex_psw_le_re;
   logic              ex_b;
   logic [2:0]        ex_soh_op;
   logic [3:0]        ex_alu_op;
   logic [3:0]        ex_ram_ctrl;
   logic              ex_l;
   logic              ex_rf_le;
   logic              ex_ub;
   logic [REG_AW-1:0] ex_rd;
   logic [DATA_W-1:0] ex_pa;
   logic [DATA_W-1:0] ex_pb;
   logic [DATA_W-1:0] ex_pc;
   logic [DATA_W-1:0] ex_instr;
   logic              stall;
   logic [CNT_W-1:0]  stall_count;

   int checks = 0;
   int fails  = 0;

   id_ex_pipeline_register #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .id_srd(id_srd), .id_psw_le_re(id_psw_le_re), .id_b(id_b), .id_soh_op(id_soh_op),
      .id_alu_op(id_alu_op), .id_ram_ctrl(id_ram_ctrl), .id_l(id_l), .id_rf_le(id_rf_le),
      .id_ub(id_ub), .id_id_sr(id_id_sr), .id_ra(id_ra), .id_rb(id_rb), .id_rd(id_rd),
      .id_pa(id_pa), .id_pb(id_pb), .id_pc(id_pc), .id_instr(id_instr), .ex_flush(ex_flush),
      .ex_srd(ex_srd), .ex_psw_le_re(ex_psw_le_re), .ex_b(ex_b), .ex_soh_op(ex_soh_op),
      .ex_alu_op(ex_alu_op), .ex_ram_ctrl(ex_ram_ctrl), .ex_l(ex_l), .ex_rf_le(ex_rf_le),
      .ex_ub(ex_ub), .ex_rd(ex_rd), .ex_pa(ex_pa), .ex_pb(ex_pb), .ex_pc(ex_pc),
      .ex_instr(ex_instr), .stall(stall), .stall_count(stall_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      id_srd = '0; id_psw_le_re = '0; id_b = 0; id_soh_op = '0; id_alu_op = '0;
      id_ram_ctrl = '0; id_l = 0; id_rf_le = 0; id_ub = 0; id_id_sr = '0;
      id_ra = '0; id_rb = '0; id_rd = '0; id_pa = '0; id_pb = '0; id_pc = '0;
      id_instr = '0; ex_flush = 0;
   endtask

   task automatic present_ldw(input logic [4:0] rd, input logic [1:0] sr);
      clear_inputs();
      id_l = 1; id_rf_le = 1; id_ram_ctrl = 4'h3; id_rd = rd; id_id_sr = sr;
      id_ra = 5'd1; id_pc = 32'h80; id_instr = 32'hC000_0000;
   endtask

   task automatic present_add(input logic [4:0] ra, input logic [4:0] rb, input logic [1:0] sr);
      clear_inputs();
      id_rf_le = 1; id_alu_op = 4'h0; id_rd = 5'd6; id_ra = ra; id_rb = rb; id_id_sr = sr;
      id_pa = 32'h11; id_pb = 32'h22; id_pc = 32'h84; id_instr = 32'h1234_5678;
   endtask

   initial begin
      int exp_cnt;
      rst_n = 0;
      clear_inputs();
      #12;
      check("reset_ex_l", ex_l, 0);
      check("reset_ex_pc", ex_pc, 0);
      check("reset_stall", stall, 0);
      check("reset_count", stall_count, 0);
      rst_n = 1;
      tick();

      // pass-through ADD
      clear_inputs();
      id_rf_le = 1; id_alu_op = 4'h0; id_rd = 5'd3; id_pa = 32'd5; id_pb = 32'd7;
      id_pc = 32'h40; id_instr = 32'hA5A5_0003; id_id_sr = 2'b11; id_ra = 5'd1; id_rb = 5'd2;
      id_soh_op = 3'd5; id_srd = 2'd2; id_psw_le_re = 2'd1; id_ram_ctrl = 4'h9; id_ub = 1; id_b = 1;
      #1;
      check("pass_stall", stall, 0);
      tick();
      check("pass_alu_op", ex_alu_op, 0);
      check("pass_rd", ex_rd, 3);
      check("pass_pa", ex_pa, 5);
      check("pass_pb", ex_pb, 7);
      check("pass_pc", ex_pc, 32'h40);
      check("pass_instr", ex_instr, 32'hA5A5_0003);
      check("pass_rf_le", ex_rf_le, 1);
      check("pass_soh_op", ex_soh_op, 5);
      check("pass_srd", ex_srd, 2);
      check("pass_psw", ex_psw_le_re, 1);
      check("pass_ram_ctrl", ex_ram_ctrl, 9);
      check("pass_ub_b", {ex_ub, ex_b}, 2'b11);

      // load-use: LDW rd=4 then ADD ra=4
      present_ldw(5'd4, 2'b10);
      tick();
      check("lu_ex_l", ex_l, 1);
      present_add(5'd4, 5'd5, 2'b11);
      #1;
      check("lu_stall", stall, 1);
      tick();
      check("lu_bubble_l", ex_l, 0);
      check("lu_bubble_rd", ex_rd, 0);
      check("lu_bubble_pa", ex_pa, 0);
      check("lu_bubble_instr", ex_instr, 0);
      check("lu_count", stall_count, 1);
      check("lu_stall_drop", stall, 0);
      tick();
      check("lu_add_rd", ex_rd, 6);
      check("lu_add_pa", ex_pa, 32'h11);
      check("lu_add_instr", ex_instr, 32'h1234_5678);
      check("lu_count_hold", stall_count, 1);

      // GR0 destination never stalls
      present_ldw(5'd0, 2'b00);
      tick();
      present_add(5'd0, 5'd0, 2'b11);
      #1;
      check("gr0_stall", stall, 0);

      // id_sr=00 never stalls; rb path alone does
      present_ldw(5'd4, 2'b00);
      tick();
      clear_inputs();
      id_rf_le = 1; id_rd = 5'd7; id_ra = 5'd4; id_rb = 5'd4; id_id_sr = 2'b00;
      #1;
      check("ldil_stall", stall, 0);
      id_id_sr = 2'b01; id_ra = 5'd0;
      #1;
      check("rb_stall", stall, 1);
      id_id_sr = 2'b10; id_ra = 5'd9;
      #1;
      check("ra_mismatch_stall", stall, 0);

      // flush beats stall
      present_add(5'd4, 5'd4, 2'b11);
      ex_flush = 1;
      #1;
      check("flush_stall", stall, 0);
      tick();
      check("flush_ex_l", ex_l, 0);
      check("flush_ex_rd", ex_rd, 0);
      check("flush_ex_instr", ex_instr, 0);
      check("flush_count", stall_count, 1);
      ex_flush = 0;

      // saturation at 15 with a 4-bit counter
      exp_cnt = 1;
      for (int i = 0; i < 20; i++) begin
         present_ldw(5'd4, 2'b00);
         tick();
         present_add(5'd4, 5'd0, 2'b10);
         tick();
         if (exp_cnt < 15) exp_cnt++;
         check($sformatf("sat_count_%0d", i), stall_count, exp_cnt);
      end
      check("sat_final", stall_count, 15);

      // reset asserted mid-stall clears without a clock edge
      present_ldw(5'd4, 2'b00);
      tick();
      present_add(5'd4, 5'd0, 2'b11);
      #1;
      check("mid_stall_pre", stall, 1);
      #1;
      rst_n = 0;
      #1;
      check("mid_rst_ex_l", ex_l, 0);
      check("mid_rst_ex_rd", ex_rd, 0);
      check("mid_rst_stall", stall, 0);
      check("mid_rst_count", stall_count, 0);
      check("mid_rst_ex_instr", ex_instr, 0);

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
